// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default depth.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;

  // Width-generic: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus: request/pointer inputs and registered status outputs.
// slave = read controller, master = consumer / CDC glue driving it.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  r_inc;
  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic                  uf_clr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  underflow;

  modport slave (
    input  r_inc,
    input  rq2_wptr,
    input  uf_clr,
    output rd_addr,
    output rd_ptr,
    output empty,
    output almost_empty,
    output rd_level,
    output underflow
  );

  modport master (
    output r_inc,
    output rq2_wptr,
    output uf_clr,
    input  rd_addr,
    input  rd_ptr,
    input  empty,
    input  almost_empty,
    input  rd_level,
    input  underflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Parametrised Gray-to-binary XOR-prefix converter (combinational).
// Shared by the read and write pointer controllers.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin      = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: pointers, RAM address, empty/level flags.
// Optional sticky underflow flag enabled by defining FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_THRESH  = 1
) (
  input  logic r_clk,
  input  logic r_rst,
  fifo_rd_ctrl_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wbin;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic          rinc;

  fifo_gray2bin #(.W(PW)) u_wdec (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  // Flags look ahead to the post-read pointer so empty rises on the last read.
  always_comb begin
    rinc    = bus.r_inc & ~empty_q;
    rbin_d  = rbin_q + PW'(rinc);
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    level_d = wbin - rbin_d;
    empty_d = (rgray_d == bus.rq2_wptr);
    ae_d    = (level_d <= AE_T);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
    end
  end

  assign bus.rd_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign bus.rd_ptr       = rgray_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_level     = level_q;

`ifdef FIFO_RD_UNDERFLOW_EN
  logic uf_q, uf_d;

  // A fresh underflow wins over a simultaneous clear.
  always_comb begin
    uf_d = (bus.r_inc & empty_q) | (uf_q & ~bus.uf_clr);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      uf_q <= 1'b0;
    end else begin
      uf_q <= uf_d;
    end
  end

  assign bus.underflow = uf_q;
`else
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=3, AE_THRESH=1).
// Behavioural model pushes expected outputs; tests pop and compare after each edge.
module tb_fifo_rd_ctrl;

  logic r_clk = 1'b0;
  logic r_rst = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(3)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus.slave)
  );

  always #5 r_clk = ~r_clk;

  // {rd_addr, rd_ptr, empty, almost_empty, rd_level, underflow}
  logic [13:0] obs;
  assign obs = {bus.rd_addr, bus.rd_ptr, bus.empty,
                bus.almost_empty, bus.rd_level, bus.underflow};

  localparam logic [13:0] RST_VEC = {3'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0};

  logic [13:0] sb[$];

  int   m_rbin  = 0;
  int   m_wbin  = 0;
  logic m_empty = 1'b1;
  logic m_uf    = 1'b0;

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic model_reset();
    m_rbin  = 0;
    m_wbin  = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic drive(input logic inc, input logic [3:0] wp, input logic clr);
    int   lvl;
    logic rd;
    @(negedge r_clk);
    bus.r_inc    = inc;
    bus.rq2_wptr = wp;
    bus.uf_clr   = clr;
    rd = inc && !m_empty;
`ifdef FIFO_RD_UNDERFLOW_EN
    m_uf = (inc && m_empty) || (m_uf && !clr);
`endif
    m_rbin  = (m_rbin + int'(rd)) & 15;
    m_wbin  = g2b(wp);
    lvl     = (m_wbin - m_rbin) & 15;
    m_empty = (lvl == 0);
    sb.push_back({m_rbin[2:0], b2g(m_rbin), m_empty,
                  lvl <= 1, lvl[3:0], m_uf});
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.r_inc    = 1'b1;
    bus.rq2_wptr = 4'b0000;
    bus.uf_clr   = 1'b0;
    r_rst        = 1'b0;
    model_reset();
    repeat (2) @(posedge r_clk);
    #1;
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset: got %b want %b", obs, RST_VEC);
    end
    @(negedge r_clk);
    bus.r_inc = 1'b0;
    r_rst     = 1'b1;
    drive(1'b1, 4'b0000, 1'b0);
    tests_run++;
    if (obs !== sb[0]) begin
      tests_failed++;
      $display("FAIL read_when_empty_after_reset: got %b want %b", obs, sb[0]);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_fill();
    logic [13:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b0110, 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL fill[%0d]: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_burst_read();
    logic [13:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0110, 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL burst[%0d]: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp;
    logic [3:0]  prev;
    prev = bus.rd_ptr;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b1101, 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got %b want %b", i, obs, exp);
      end
      tests_run++;
      if (prev !== bus.rd_ptr && $countones(prev ^ bus.rd_ptr) != 1) begin
        tests_failed++;
        $display("FAIL wrap_gray_step[%0d]: got %b->%b want one bit",
                 i, prev, bus.rd_ptr);
      end
      prev = bus.rd_ptr;
    end
  endtask

  task automatic test_underflow();
    logic [13:0] exp;
    logic        clr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        inc[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(inc[i], 4'b1101, clr[i]);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL underflow[%0d]: got %b want %b", i, obs, exp);
      end
    end
    drive(1'b0, 4'b1101, 1'b0);
    exp = sb.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL underflow_idle: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_full_wrap();
    logic [13:0] exp;
    logic [3:0]  prev;
    logic [3:0]  start;
    start = bus.rd_ptr;
    prev  = start;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, b2g((m_rbin + 8) & 15), 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL full_wrap[%0d]: got %b want %b", i, obs, exp);
      end
      tests_run++;
      if (prev !== bus.rd_ptr && $countones(prev ^ bus.rd_ptr) != 1) begin
        tests_failed++;
        $display("FAIL full_wrap_gray_step[%0d]: got %b->%b want one bit",
                 i, prev, bus.rd_ptr);
      end
      prev = bus.rd_ptr;
    end
    tests_run++;
    if (bus.rd_ptr !== start) begin
      tests_failed++;
      $display("FAIL full_wrap_return: got %b want %b", bus.rd_ptr, start);
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    int          n = 0;
    while (m_rbin != 5 && n < 20) begin
      drive(1'b1, b2g((m_rbin + 8) & 15), 1'b0);
      exp = sb.pop_front();
      n++;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL pre_reset_burst[%0d]: got %b want %b", n, obs, exp);
      end
    end
    tests_run++;
    if (m_rbin != 5) begin
      tests_failed++;
      $display("FAIL pre_reset_reach: got rbin %0d want 5", m_rbin);
    end
    @(negedge r_clk);
    #2;
    bus.r_inc = 1'b1;
    r_rst     = 1'b0;
    #1;
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL async_reset: got %b want %b", obs, RST_VEC);
    end
    @(posedge r_clk);
    #1;
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_hold: got %b want %b", obs, RST_VEC);
    end
    @(negedge r_clk);
    bus.r_inc = 1'b0;
    r_rst     = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_burst_read();
    test_wrap();
    test_underflow();
    test_full_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
